// File: rtl/dmem_pipe.sv
// dmem_pipe: byte/half/word data memory, valid/ready requests, LATENCY-deep read pipe,
// credit-managed in-order response FIFO. Define DMEM_STATS_EN for ld/st/err counters.
module dmem_pipe #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 1,
  parameter int RSP_DEPTH   = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_unsigned_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o
`ifdef DMEM_STATS_EN
  ,
  output logic [31:0] ld_cnt_o,
  output logic [31:0] st_cnt_o,
  output logic [31:0] err_cnt_o
`endif
);

  localparam int IW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int CW = $clog2(RSP_DEPTH + 1);
  localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam logic [31:0] DEPTH_L = DEPTH_WORDS;
  localparam logic [CW:0] RSP_L   = RSP_DEPTH;

  logic [31:0] mem_q [DEPTH_WORDS];

  logic          acc;
  logic [29:0]   waddr;
  logic [1:0]    off;
  logic [IW-1:0] idx;
  logic          size_bad;
  logic          mis;
  logic          oor;
  logic          bad;
  logic [3:0]    be;
  logic [31:0]   wd;
  logic [31:0]   rword;
  logic [15:0]   sh;
  logic [31:0]   ld_data;
  logic [31:0]   in_data;

  logic          ready_q, ready_d;

  assign acc   = req_valid_i & ready_q;
  assign waddr = req_addr_i[31:2];
  assign off   = req_addr_i[1:0];
  assign idx   = waddr[IW-1:0];
  assign oor   = {2'b00, waddr} >= DEPTH_L;
  assign bad   = size_bad | mis | oor;

  always_comb begin
    size_bad = 1'b0;
    mis      = 1'b0;
    be       = 4'b0000;
    wd       = '0;
    unique case (1'b1)
      (req_size_i == 2'b00): begin
        be = 4'b0001 << off;
        wd = {4{req_wdata_i[7:0]}};
      end
      (req_size_i == 2'b01): begin
        be  = 4'b0011 << {off[1], 1'b0};
        wd  = {2{req_wdata_i[15:0]}};
        mis = off[0];
      end
      (req_size_i == 2'b10): begin
        be  = 4'b1111;
        wd  = req_wdata_i;
        mis = |off;
      end
      default: size_bad = 1'b1;
    endcase
  end

  assign rword = mem_q[idx];
  assign sh    = 16'(rword >> {off, 3'b000});

  always_comb begin
    ld_data = '0;
    unique case (1'b1)
      (req_size_i == 2'b00):
        ld_data = req_unsigned_i ? {24'b0, sh[7:0]}
                                 : {{24{sh[7]}}, sh[7:0]};
      (req_size_i == 2'b01):
        ld_data = req_unsigned_i ? {16'b0, sh}
                                 : {{16{sh[15]}}, sh};
      (req_size_i == 2'b10):
        ld_data = rword;
      default: ld_data = '0;
    endcase
  end

  assign in_data = (req_we_i | bad) ? '0 : ld_data;

  always_ff @(posedge clk_i) begin
    if (acc && req_we_i && !bad) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem_q[idx][8*b +: 8] <= wd[8*b +: 8];
      end
    end
  end

  logic        push_vld;
  logic        push_err;
  logic [31:0] push_data;

  // Accept edge counts as the first latency stage.
  generate
    if (LATENCY == 1) begin : g_nopipe
      assign push_vld  = acc;
      assign push_err  = bad;
      assign push_data = in_data;
    end else begin : g_pipe
      logic [LATENCY-2:0] v_q;
      logic [LATENCY-2:0] e_q;
      logic [31:0]        d_q [LATENCY-1];

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          v_q <= '0;
          e_q <= '0;
          for (int i = 0; i < LATENCY - 1; i++) d_q[i] <= '0;
        end else begin
          v_q[0] <= acc;
          e_q[0] <= bad;
          d_q[0] <= in_data;
          for (int i = 1; i < LATENCY - 1; i++) begin
            v_q[i] <= v_q[i-1];
            e_q[i] <= e_q[i-1];
            d_q[i] <= d_q[i-1];
          end
        end
      end

      assign push_vld  = v_q[LATENCY-2];
      assign push_err  = e_q[LATENCY-2];
      assign push_data = d_q[LATENCY-2];
    end
  endgenerate

  logic [31:0]   fd_q [RSP_DEPTH];
  logic          fe_q [RSP_DEPTH];
  logic [PW-1:0] wr_q, wr_d;
  logic [PW-1:0] rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] infl_q, infl_d;
  logic          pop;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(RSP_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign rsp_valid_o = (cnt_q != '0);
  assign pop         = rsp_valid_o & rsp_ready_i;
  assign rsp_rdata_o = rsp_valid_o ? fd_q[rd_q] : '0;
  assign rsp_err_o   = rsp_valid_o & fe_q[rd_q];
  assign req_ready_o = ready_q;

  always_comb begin
    wr_d    = wr_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q + CW'(push_vld) - CW'(pop);
    infl_d  = infl_q + CW'(acc) - CW'(push_vld);
    ready_d = ({1'b0, infl_d} + {1'b0, cnt_d}) < RSP_L;
    if (push_vld) wr_d = nxt(wr_q);
    if (pop)      rd_d = nxt(rd_q);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      infl_q  <= '0;
      ready_q <= 1'b0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      infl_q  <= infl_d;
      ready_q <= ready_d;
    end
  end

  // Credits guarantee a free slot whenever something is pushed.
  always_ff @(posedge clk_i) begin
    if (push_vld) begin
      fd_q[wr_q] <= push_data;
      fe_q[wr_q] <= push_err;
    end
  end

`ifdef DMEM_STATS_EN
  logic [31:0] ld_q, ld_d;
  logic [31:0] st_q, st_d;
  logic [31:0] er_q, er_d;

  always_comb begin
    ld_d = ld_q;
    st_d = st_q;
    er_d = er_q;
    if (acc) begin
      unique case (1'b1)
        bad:       er_d = er_q + 32'd1;
        req_we_i:  st_d = st_q + 32'd1;
        default:   ld_d = ld_q + 32'd1;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ld_q <= '0;
      st_q <= '0;
      er_q <= '0;
    end else begin
      ld_q <= ld_d;
      st_q <= st_d;
      er_q <= er_d;
    end
  end

  assign ld_cnt_o  = ld_q;
  assign st_cnt_o  = st_q;
  assign err_cnt_o = er_q;
`endif

endmodule

// File: tb/tb_dmem_pipe.sv
// Directed bench for dmem_pipe: instance a uses default parameters,
// instance b uses LATENCY=3, RSP_DEPTH=4 for streaming.
module tb_dmem_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  logic        a_req_valid, a_req_ready, a_req_we, a_req_unsigned;
  logic [1:0]  a_req_size;
  logic [31:0] a_req_addr, a_req_wdata, a_rsp_rdata;
  logic        a_rsp_valid, a_rsp_ready, a_rsp_err;

  logic        b_req_valid, b_req_ready, b_req_we, b_req_unsigned;
  logic [1:0]  b_req_size;
  logic [31:0] b_req_addr, b_req_wdata, b_rsp_rdata;
  logic        b_rsp_valid, b_rsp_ready, b_rsp_err;

`ifdef DMEM_STATS_EN
  logic [31:0] a_ld_cnt, a_st_cnt, a_err_cnt;
  logic [31:0] b_ld_cnt, b_st_cnt, b_err_cnt;
`endif

  dmem_pipe u_a (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .req_valid_i    (a_req_valid),
    .req_ready_o    (a_req_ready),
    .req_we_i       (a_req_we),
    .req_size_i     (a_req_size),
    .req_unsigned_i (a_req_unsigned),
    .req_addr_i     (a_req_addr),
    .req_wdata_i    (a_req_wdata),
    .rsp_valid_o    (a_rsp_valid),
    .rsp_ready_i    (a_rsp_ready),
    .rsp_rdata_o    (a_rsp_rdata),
    .rsp_err_o      (a_rsp_err)
`ifdef DMEM_STATS_EN
    ,
    .ld_cnt_o       (a_ld_cnt),
    .st_cnt_o       (a_st_cnt),
    .err_cnt_o      (a_err_cnt)
`endif
  );

  dmem_pipe #(.LATENCY(3), .RSP_DEPTH(4)) u_b (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .req_valid_i    (b_req_valid),
    .req_ready_o    (b_req_ready),
    .req_we_i       (b_req_we),
    .req_size_i     (b_req_size),
    .req_unsigned_i (b_req_unsigned),
    .req_addr_i     (b_req_addr),
    .req_wdata_i    (b_req_wdata),
    .rsp_valid_o    (b_rsp_valid),
    .rsp_ready_i    (b_rsp_ready),
    .rsp_rdata_o    (b_rsp_rdata),
    .rsp_err_o      (b_rsp_err)
`ifdef DMEM_STATS_EN
    ,
    .ld_cnt_o       (b_ld_cnt),
    .st_cnt_o       (b_st_cnt),
    .err_cnt_o      (b_err_cnt)
`endif
  );

  // One request on instance a; returns response fields and latency (-1 on timeout).
  task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdat,
                        output logic [31:0] rd, output logic er, output int lat);
    int n;
    rd  = '0;
    er  = 1'b0;
    lat = -1;
    @(negedge clk);
    a_req_valid = 1'b1; a_req_we = we; a_req_size = sz;
    a_req_unsigned = uns; a_req_addr = addr; a_req_wdata = wdat;
    n = 0;
    while (!a_req_ready && n < 20) begin @(negedge clk); n++; end
    if (n >= 20) begin a_req_valid = 1'b0; return; end
    @(posedge clk);
    #1 a_req_valid = 1'b0;
    for (n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (a_rsp_valid) begin
        lat = n; rd = a_rsp_rdata; er = a_rsp_err;
        break;
      end
    end
  endtask

  task automatic test_reset();
    logic [31:0] rd; logic er; int lat;
    repeat (2) @(negedge clk);
    checks++; if (a_req_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b exp 0", a_req_ready); end
    checks++; if (a_rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid: got %b exp 0", a_rsp_valid); end
    checks++; if (a_rsp_rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata: got %h exp 0", a_rsp_rdata); end
    checks++; if (a_rsp_err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b exp 0", a_rsp_err); end
    rst_n = 1'b1;
    #1;
    checks++; if (a_req_ready !== 1'b0) begin errors++; $display("FAIL rst_release_ready: got %b exp 0", a_req_ready); end
    @(posedge clk); #1;
    checks++; if (a_req_ready !== 1'b1) begin errors++; $display("FAIL rst_ready_rise_a: got %b exp 1", a_req_ready); end
    checks++; if (b_req_ready !== 1'b1) begin errors++; $display("FAIL rst_ready_rise_b: got %b exp 1", b_req_ready); end
    do_req(1'b1, 2'b10, 1'b0, 32'd200, 32'hCAFE_0001, rd, er, lat);
    // loads in flight on both instances, then reset
    @(negedge clk);
    a_req_valid = 1'b1; a_req_we = 1'b0; a_req_size = 2'b10; a_req_addr = 32'd200;
    b_req_valid = 1'b1; b_req_we = 1'b0; b_req_size = 2'b10; b_req_addr = 32'd0;
    @(posedge clk);
    #1 a_req_valid = 1'b0; b_req_valid = 1'b0;
    #1 rst_n = 1'b0;
    @(negedge clk);
    checks++; if (a_rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_rsp_valid: got %b exp 0", a_rsp_valid); end
    checks++; if (a_req_ready !== 1'b0) begin errors++; $display("FAIL rst_mid_ready: got %b exp 0", a_req_ready); end
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    checks++; if (a_rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_drop_a: got %b exp 0", a_rsp_valid); end
    checks++; if (b_rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_drop_b: got %b exp 0", b_rsp_valid); end
    checks++; if (a_req_ready !== 1'b1) begin errors++; $display("FAIL rst_after_ready: got %b exp 1", a_req_ready); end
    do_req(1'b0, 2'b10, 1'b0, 32'd200, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'hCAFE_0001) begin errors++; $display("FAIL rst_mem_kept: got %h exp cafe0001", rd); end
  endtask

  task automatic test_word();
    logic [31:0] rd; logic er; int lat;
    do_req(1'b1, 2'b10, 1'b0, 32'd100, 32'h0000_0019, rd, er, lat);
    checks++; if ({er, rd} !== 33'h0) begin errors++; $display("FAIL sw_rsp: got err %b data %h exp 0/0", er, rd); end
    checks++; if (lat !== 1) begin errors++; $display("FAIL sw_lat: got %0d exp 1", lat); end
    do_req(1'b0, 2'b10, 1'b0, 32'd100, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'h19) begin errors++; $display("FAIL lw_data: got %h exp 19", rd); end
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL lw_err: got %b exp 0", er); end
    checks++; if (lat !== 1) begin errors++; $display("FAIL lw_lat: got %0d exp 1", lat); end
  endtask

  task automatic test_byte_ext();
    logic [31:0] rd; logic er; int lat;
    do_req(1'b1, 2'b10, 1'b0, 32'd8, 32'h8000_00F0, rd, er, lat);
    do_req(1'b0, 2'b00, 1'b0, 32'd8, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'hFFFF_FFF0) begin errors++; $display("FAIL lb: got %h exp fffffff0", rd); end
    do_req(1'b0, 2'b00, 1'b1, 32'd8, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'h0000_00F0) begin errors++; $display("FAIL lbu: got %h exp 000000f0", rd); end
    do_req(1'b0, 2'b01, 1'b0, 32'd10, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'hFFFF_8000) begin errors++; $display("FAIL lh: got %h exp ffff8000", rd); end
    do_req(1'b0, 2'b01, 1'b1, 32'd10, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'h0000_8000) begin errors++; $display("FAIL lhu: got %h exp 00008000", rd); end
    do_req(1'b0, 2'b00, 1'b0, 32'd11, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_lane3: got %h exp ffffff80", rd); end
    do_req(1'b1, 2'b00, 1'b0, 32'd9, 32'hAAAA_AA7F, rd, er, lat);
    do_req(1'b0, 2'b10, 1'b0, 32'd8, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'h8000_7FF0) begin errors++; $display("FAIL sb_merge: got %h exp 80007ff0", rd); end
    do_req(1'b1, 2'b01, 1'b0, 32'd10, 32'h5555_1234, rd, er, lat);
    do_req(1'b0, 2'b10, 1'b0, 32'd8, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'h1234_7FF0) begin errors++; $display("FAIL sh_merge: got %h exp 12347ff0", rd); end
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic er; int lat;
    do_req(1'b1, 2'b10, 1'b0, 32'd4, 32'h1122_3344, rd, er, lat);
    do_req(1'b1, 2'b10, 1'b0, 32'd0, 32'h0000_0077, rd, er, lat);
    do_req(1'b1, 2'b01, 1'b0, 32'd5, 32'h0000_BEEF, rd, er, lat);
    checks++; if ({er, rd} !== {1'b1, 32'h0}) begin errors++; $display("FAIL sh_mis: got err %b data %h exp 1/0", er, rd); end
    checks++; if (lat !== 1) begin errors++; $display("FAIL err_lat: got %0d exp 1", lat); end
    do_req(1'b0, 2'b10, 1'b0, 32'd4, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'h1122_3344) begin errors++; $display("FAIL err_nowrite: got %h exp 11223344", rd); end
    do_req(1'b0, 2'b10, 1'b0, 32'd2, 32'h0, rd, er, lat);
    checks++; if ({er, rd} !== {1'b1, 32'h0}) begin errors++; $display("FAIL lw_mis: got err %b data %h exp 1/0", er, rd); end
    do_req(1'b0, 2'b10, 1'b0, 32'd4096, 32'h0, rd, er, lat);
    checks++; if ({er, rd} !== {1'b1, 32'h0}) begin errors++; $display("FAIL lw_oor: got err %b data %h exp 1/0", er, rd); end
    do_req(1'b0, 2'b11, 1'b0, 32'd100, 32'h0, rd, er, lat);
    checks++; if ({er, rd} !== {1'b1, 32'h0}) begin errors++; $display("FAIL size11: got err %b data %h exp 1/0", er, rd); end
    do_req(1'b1, 2'b10, 1'b0, 32'd4096, 32'hDEAD_BEEF, rd, er, lat);
    checks++; if (er !== 1'b1) begin errors++; $display("FAIL sw_oor: got %b exp 1", er); end
    do_req(1'b0, 2'b10, 1'b0, 32'd0, 32'h0, rd, er, lat);
    checks++; if ({er, rd} !== {1'b0, 32'h77}) begin errors++; $display("FAIL oor_alias: got err %b data %h exp 0/77", er, rd); end
  endtask

  task automatic test_backpressure();
    logic [31:0] rd; logic er; int lat;
    do_req(1'b1, 2'b10, 1'b0, 32'h20, 32'hA, rd, er, lat);
    do_req(1'b1, 2'b10, 1'b0, 32'h24, 32'hB, rd, er, lat);
    do_req(1'b1, 2'b10, 1'b0, 32'h28, 32'hC, rd, er, lat);
    @(negedge clk);
    a_rsp_ready = 1'b0;
    a_req_valid = 1'b1; a_req_we = 1'b0; a_req_size = 2'b10; a_req_addr = 32'h20;
    checks++; if (a_req_ready !== 1'b1) begin errors++; $display("FAIL bp_ready0: got %b exp 1", a_req_ready); end
    @(posedge clk); #1 a_req_addr = 32'h24;
    @(negedge clk);
    checks++; if (a_req_ready !== 1'b1) begin errors++; $display("FAIL bp_ready1: got %b exp 1", a_req_ready); end
    @(posedge clk); #1 a_req_addr = 32'h28;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++; if (a_req_ready !== 1'b0) begin errors++; $display("FAIL bp_full_ready: got %b exp 0", a_req_ready); end
      checks++; if ({a_rsp_valid, a_rsp_err, a_rsp_rdata} !== {2'b10, 32'hA}) begin
        errors++; $display("FAIL bp_hold: got v %b e %b d %h exp 1/0/a", a_rsp_valid, a_rsp_err, a_rsp_rdata);
      end
    end
    a_rsp_ready = 1'b1;
    @(negedge clk);
    checks++; if ({a_rsp_valid, a_rsp_rdata} !== {1'b1, 32'hB}) begin errors++; $display("FAIL bp_pop2: got v %b d %h exp 1/b", a_rsp_valid, a_rsp_rdata); end
    checks++; if (a_req_ready !== 1'b1) begin errors++; $display("FAIL bp_credit: got %b exp 1", a_req_ready); end
    @(posedge clk); #1 a_req_valid = 1'b0;
    @(negedge clk);
    checks++; if ({a_rsp_valid, a_rsp_rdata} !== {1'b1, 32'hC}) begin errors++; $display("FAIL bp_third: got v %b d %h exp 1/c", a_rsp_valid, a_rsp_rdata); end
    @(negedge clk);
    checks++; if (a_rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_drain: got %b exp 0", a_rsp_valid); end
  endtask

  task automatic test_streaming(input logic we);
    int          acc_cyc [16];
    int          rsp_cyc [16];
    logic [31:0] rsp_d [16];
    logic        rsp_e [16];
    int          stalls;
    int          got;
    stalls = 0;
    got    = 0;
    fork
      begin
        int n;
        for (int i = 0; i < 16; i++) begin
          @(negedge clk);
          b_req_valid = 1'b1; b_req_we = we; b_req_size = 2'b10; b_req_unsigned = 1'b0;
          b_req_addr = 32'h100 + 32'(i) * 4; b_req_wdata = 32'h5A00_0000 + 32'(i * 7);
          n = 0;
          while (!b_req_ready && n < 50) begin stalls++; @(negedge clk); n++; end
          acc_cyc[i] = cyc;
          @(posedge clk);
        end
        @(negedge clk);
        b_req_valid = 1'b0;
      end
      begin
        int n;
        for (int k = 0; k < 16; k++) begin
          n = 0;
          do begin @(negedge clk); n++; end while (!b_rsp_valid && n < 60);
          if (!b_rsp_valid) break;
          rsp_cyc[k] = cyc; rsp_d[k] = b_rsp_rdata; rsp_e[k] = b_rsp_err;
          got++;
        end
      end
    join
    checks++; if (got !== 16) begin errors++; $display("FAIL stream_count we=%b: got %0d exp 16", we, got); end
    checks++; if (stalls !== 0) begin errors++; $display("FAIL stream_stalls we=%b: got %0d exp 0", we, stalls); end
    for (int k = 0; k < got; k++) begin
      logic [32:0] exp_r;
      exp_r = we ? 33'h0 : {1'b0, 32'h5A00_0000 + 32'(k * 7)};
      checks++; if ({rsp_e[k], rsp_d[k]} !== exp_r) begin
        errors++; $display("FAIL stream_data we=%b #%0d: got %h exp %h", we, k, {rsp_e[k], rsp_d[k]}, exp_r);
      end
      checks++; if (rsp_cyc[k] !== acc_cyc[0] + 3 + k) begin
        errors++; $display("FAIL stream_timing we=%b #%0d: got %0d exp %0d", we, k, rsp_cyc[k], acc_cyc[0] + 3 + k);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    a_req_valid = 1'b0; a_req_we = 1'b0; a_req_size = 2'b00; a_req_unsigned = 1'b0;
    a_req_addr = '0; a_req_wdata = '0; a_rsp_ready = 1'b1;
    b_req_valid = 1'b0; b_req_we = 1'b0; b_req_size = 2'b00; b_req_unsigned = 1'b0;
    b_req_addr = '0; b_req_wdata = '0; b_rsp_ready = 1'b1;
    test_reset();
    test_word();
    test_byte_ext();
    test_errors();
    test_backpressure();
    test_streaming(1'b1);
    test_streaming(1'b0);
`ifdef DMEM_STATS_EN
    @(negedge clk);
    checks++; if (b_ld_cnt !== 32'd16) begin errors++; $display("FAIL stats_ld: got %0d exp 16", b_ld_cnt); end
    checks++; if (b_st_cnt !== 32'd16) begin errors++; $display("FAIL stats_st: got %0d exp 16", b_st_cnt); end
    checks++; if (b_err_cnt !== 32'd0) begin errors++; $display("FAIL stats_err: got %0d exp 0", b_err_cnt); end
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout exp completion");
    $fatal(1, "watchdog");
  end

endmodule
